// File: rtl/elastic_config_loader_if.sv
// Elastic config stream between the array-level source and one loader.
//   master : stream source (drives entry fields + valid_input, sees stop_input)
//   slave  : elastic_config_loader (takes the entry, drives stop_input)
// A transfer happens in any cycle with valid_input && !stop_input.
interface elastic_config_loader_if #(
  parameter int DATA_WIDTH           = 32,
  parameter int INPUT_NUM_BIT_LENGTH = 3,
  parameter int NEIGHBOR_PE_NUM      = 4,
  parameter int OPERATION_BIT_LENGTH = 4
);
  logic [INPUT_NUM_BIT_LENGTH-1:0] in_input_PE_index_1;
  logic [INPUT_NUM_BIT_LENGTH-1:0] in_input_PE_index_2;
  logic [NEIGHBOR_PE_NUM-1:0]      in_output_PE_index;
  logic [OPERATION_BIT_LENGTH-1:0] in_op;
  logic [DATA_WIDTH-1:0]           in_const_data;
  logic                            valid_input;
  logic                            stop_input;

  modport master (
    output in_input_PE_index_1, in_input_PE_index_2, in_output_PE_index,
           in_op, in_const_data, valid_input,
    input  stop_input
  );

  modport slave (
    input  in_input_PE_index_1, in_input_PE_index_2, in_output_PE_index,
           in_op, in_const_data, valid_input,
    output stop_input
  );
endinterface

// File: rtl/elastic_config_loader.sv
// elastic_config_loader: drains an elastic config stream into one PE config
// memory in context order, then pulses start_exec once and parks in RUN.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   load_request             start a load (honoured in IDLE / RUN only)
//   load_context_num         contexts to load, legal 1..CONTEXT_SIZE
//   stream (slave modport)   entry fields, valid_input in, stop_input out
//   config_*                 registered copy of the last accepted entry
//   write_config_data        write strobe, one cycle after each transfer
//   config_index             context being written
//   start_exec               single-cycle execution start pulse
//   mapping_context_max_id   load_context_num-1 of the current load
//   busy / done / error      LOAD|START / RUN / sticky illegal count
//   config_checksum          (optional) running XOR of accepted entries
//
// Optional feature macro: ELASTIC_CONFIG_LOADER_CHECKSUM_EN adds
// config_checksum; without it the port and its logic are absent.
module elastic_config_loader #(
  parameter int DATA_WIDTH              = 32,
  parameter int CONTEXT_SIZE            = 8,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
  parameter int INPUT_NUM_BIT_LENGTH    = 3,
  parameter int NEIGHBOR_PE_NUM         = 4,
  parameter int OPERATION_BIT_LENGTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load_request,
  input  logic [CONTEXT_SIZE_BIT_LENGTH:0]   load_context_num,
  elastic_config_loader_if.slave             stream,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic                               write_config_data,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               done,
  output logic                               error
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]              config_checksum
`endif
);
  localparam int CW = CONTEXT_SIZE_BIT_LENGTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_RUN} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [CW-1:0]                   max_q, max_d;
  logic [CW-1:0]                   idx_q, idx_d;
  logic                            err_q, err_d;
  logic                            wr_q, wr_d;
  logic                            start_q, start_d;
  logic [INPUT_NUM_BIT_LENGTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [NEIGHBOR_PE_NUM-1:0]      out_q, out_d;
  logic [OPERATION_BIT_LENGTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0]           cdat_q, cdat_d;

  logic cnt_ok, load_go, xfer;

  assign cnt_ok  = (load_context_num != '0) &&
                   (load_context_num <= (CW+1)'(CONTEXT_SIZE));
  assign load_go = ((state_q == S_IDLE) || (state_q == S_RUN)) && load_request && cnt_ok;
  // stop_input is low only in LOAD, so this is valid && !stop_input
  assign xfer    = (state_q == S_LOAD) && stream.valid_input;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    start_d = 1'b0;
    in1_d   = in1_q;
    in2_d   = in2_q;
    out_d   = out_q;
    op_d    = op_q;
    cdat_d  = cdat_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (load_request) begin
          if (cnt_ok) begin
            err_d   = 1'b0;
            max_d   = CW'(load_context_num - 1'b1);
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr_d   = 1'b1;
          idx_d  = cnt_q;
          in1_d  = stream.in_input_PE_index_1;
          in2_d  = stream.in_input_PE_index_2;
          out_d  = stream.in_output_PE_index;
          op_d   = stream.in_op;
          cdat_d = stream.in_const_data;
          // hold the counter on the last entry so it never wraps
          if (cnt_q == max_q) state_d = S_START;
          else                cnt_d   = cnt_q + 1'b1;
        end
      end
      S_START: begin
        // first START cycle carries the last write, second one the pulse
        if (!start_q) start_d = 1'b1;
        else          state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      in1_q   <= '0;
      in2_q   <= '0;
      out_q   <= '0;
      op_q    <= '0;
      cdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      out_q   <= out_d;
      op_q    <= op_d;
      cdat_q  <= cdat_d;
    end
  end

`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cks_q <= '0;
    else if (load_go) cks_q <= '0;
    else if (xfer)    cks_q <= cks_q ^ stream.in_const_data ^ DATA_WIDTH'(stream.in_op);
  end

  assign config_checksum = cks_q;
`endif

  assign stream.stop_input       = (state_q != S_LOAD);
  assign busy                    = (state_q == S_LOAD) || (state_q == S_START);
  assign done                    = (state_q == S_RUN);
  assign error                   = err_q;
  assign write_config_data       = wr_q;
  assign start_exec              = start_q;
  assign config_index            = idx_q;
  assign mapping_context_max_id  = max_q;
  assign config_input_PE_index_1 = in1_q;
  assign config_input_PE_index_2 = in2_q;
  assign config_output_PE_index  = out_q;
  assign config_op               = op_q;
  assign config_const_data       = cdat_q;

endmodule

// File: tb/tb_elastic_config_loader.sv
module tb_elastic_config_loader;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_request = 1'b0;
  logic [3:0]  load_context_num = '0;
  logic [2:0]  cfg_in1, cfg_in2, cfg_idx, cfg_max;
  logic [3:0]  cfg_out, cfg_op;
  logic [31:0] cfg_data;
  logic        wr, start_exec, busy, done, error;
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] cks;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int row    = 0;

  elastic_config_loader_if sif ();

  elastic_config_loader dut (
    .clk(clk), .reset_n(reset_n),
    .load_request(load_request), .load_context_num(load_context_num),
    .stream(sif),
    .config_input_PE_index_1(cfg_in1), .config_input_PE_index_2(cfg_in2),
    .config_output_PE_index(cfg_out), .config_op(cfg_op),
    .config_const_data(cfg_data), .write_config_data(wr),
    .config_index(cfg_idx), .start_exec(start_exec),
    .mapping_context_max_id(cfg_max), .busy(busy), .done(done), .error(error)
`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    , .config_checksum(cks)
`endif
  );

  always #5 clk = ~clk;

  // one record = inputs for one cycle + outputs expected in that cycle
  typedef struct {
    bit rst; bit req; logic [3:0] n; bit v; logic [31:0] c;
    bit ew; logic [2:0] ei; logic [31:0] ec;
    bit es; bit ed; bit est; bit eb; bit ee; logic [2:0] em;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int rst, req, n, v, c, ew, ei, ec,
                              es, ed, est, eb, ee, em);
    vec_t r;
    r.rst = (rst != 0); r.req = (req != 0); r.n = 4'(n); r.v = (v != 0);
    r.c = 32'(c); r.ew = (ew != 0); r.ei = 3'(ei); r.ec = 32'(ec);
    r.es = (es != 0); r.ed = (ed != 0); r.est = (est != 0);
    r.eb = (eb != 0); r.ee = (ee != 0); r.em = 3'(em);
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", nm, row, act, exp);
    end
  endtask

  // entry fields other than const/op are derived from the const value
  task automatic put(input bit v, input logic [31:0] c, input logic [3:0] op);
    sif.valid_input         = v;
    sif.in_const_data       = c;
    sif.in_op               = op;
    sif.in_input_PE_index_1 = c[2:0];
    sif.in_input_PE_index_2 = c[5:3];
    sif.in_output_PE_index  = c[7:4];
  endtask

  task automatic drive(input bit req, input int n, input bit v, input int c, input int op);
    @(negedge clk);
    load_request     = req;
    load_context_num = 4'(n);
    put(v, 32'(c), 4'(op));
    #1;
    row++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    put(1'b0, '0, '0);
    // rst req n v c | ew ei ec | es ed stop busy err max
    add(0,0,0,0,0,   0,0,0,   0,0,1,0,0,0);
    add(1,0,0,0,0,   0,0,0,   0,0,1,0,0,0);
    // n=3, valid held high; a 4th entry is offered in START and ignored
    add(1,1,3,0,0,   0,0,0,   0,0,1,0,0,0);
    add(1,0,0,1,10,  0,0,0,   0,0,0,1,0,2);
    add(1,0,0,1,20,  1,0,10,  0,0,0,1,0,2);
    add(1,0,0,1,30,  1,1,20,  0,0,0,1,0,2);
    add(1,0,0,1,40,  1,2,30,  0,0,1,1,0,2);
    add(1,0,0,0,0,   0,2,30,  1,0,1,1,0,2);
    add(1,0,0,0,0,   0,2,30,  0,1,1,0,0,2);
    // reload from RUN with valid toggling 1,0,1,0,1
    add(1,1,3,0,0,   0,2,30,  0,1,1,0,0,2);
    add(1,0,0,1,1,   0,2,30,  0,0,0,1,0,2);
    add(1,0,0,0,0,   1,0,1,   0,0,0,1,0,2);
    add(1,0,0,1,3,   0,0,1,   0,0,0,1,0,2);
    add(1,0,0,0,0,   1,1,3,   0,0,0,1,0,2);
    add(1,0,0,1,5,   0,1,3,   0,0,0,1,0,2);
    add(1,0,0,0,0,   1,2,5,   0,0,1,1,0,2);
    add(1,0,0,0,0,   0,2,5,   1,0,1,1,0,2);
    add(1,0,0,0,0,   0,2,5,   0,1,1,0,0,2);
    // illegal counts 0 and 9, then legal 2 clears error
    add(1,1,0,0,0,   0,2,5,   0,1,1,0,0,2);
    add(1,1,9,1,77,  0,2,5,   0,0,1,0,1,2);
    add(1,0,0,1,78,  0,2,5,   0,0,1,0,1,2);
    add(1,1,2,0,0,   0,2,5,   0,0,1,0,1,2);
    add(1,0,0,1,7,   0,2,5,   0,0,0,1,0,1);
    add(1,0,0,1,8,   1,0,7,   0,0,0,1,0,1);
    add(1,0,0,1,9,   1,1,8,   0,0,1,1,0,1);
    add(1,0,0,0,0,   0,1,8,   1,0,1,1,0,1);
    add(1,0,0,0,0,   0,1,8,   0,1,1,0,0,1);
    // full depth: n=8, valid high for 10 cycles, only 8 accepted
    add(1,1,8,0,0,   0,1,8,   0,1,1,0,0,1);
    add(1,0,0,1,100, 0,1,8,   0,0,0,1,0,7);
    for (int i = 1; i < 8; i++)
      add(1,0,0,1,100+i, 1,i-1,100+i-1, 0,0,0,1,0,7);
    add(1,0,0,1,108, 1,7,107, 0,0,1,1,0,7);
    add(1,0,0,1,109, 0,7,107, 1,0,1,1,0,7);
    add(1,0,0,0,0,   0,7,107, 0,1,1,0,0,7);
    // async reset after 2 of 4 entries, then a single-entry load
    add(1,1,4,0,0,   0,7,107, 0,1,1,0,0,7);
    add(1,0,0,1,1,   0,7,107, 0,0,0,1,0,3);
    add(1,0,0,1,2,   1,0,1,   0,0,0,1,0,3);
    add(0,0,0,1,3,   0,0,0,   0,0,1,0,0,0);
    add(1,1,1,0,0,   0,0,0,   0,0,1,0,0,0);
    add(1,0,0,1,55,  0,0,0,   0,0,0,1,0,0);
    add(1,0,0,0,0,   1,0,55,  0,0,1,1,0,0);
    add(1,0,0,0,0,   0,0,55,  1,0,1,1,0,0);
    add(1,0,0,0,0,   0,0,55,  0,1,1,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset_n          = tbl[i].rst;
      load_request     = tbl[i].req;
      load_context_num = tbl[i].n;
      put(tbl[i].v, tbl[i].c, tbl[i].c[3:0]);
      #1;
      row = i;
      chk("write_config_data", 32'(wr), 32'(tbl[i].ew));
      chk("config_index", 32'(cfg_idx), 32'(tbl[i].ei));
      chk("config_const_data", cfg_data, tbl[i].ec);
      chk("config_op", 32'(cfg_op), 32'(tbl[i].ec[3:0]));
      chk("config_input_PE_index_1", 32'(cfg_in1), 32'(tbl[i].ec[2:0]));
      chk("start_exec", 32'(start_exec), 32'(tbl[i].es));
      chk("done", 32'(done), 32'(tbl[i].ed));
      chk("stop_input", 32'(sif.stop_input), 32'(tbl[i].est));
      chk("busy", 32'(busy), 32'(tbl[i].eb));
      chk("error", 32'(error), 32'(tbl[i].ee));
      chk("mapping_context_max_id", 32'(cfg_max), 32'(tbl[i].em));
    end

    // load_request (legal and illegal) is ignored while LOAD/START
    row = 1000;
    drive(1, 2, 0, 0, 0);
    drive(1, 5, 1, 11, 11);
    chk("seq_max_id_load", 32'(cfg_max), 32'd1);
    drive(1, 0, 1, 12, 12);
    chk("seq_wr0", 32'(wr), 32'd1);
    chk("seq_idx0", 32'(cfg_idx), 32'd0);
    chk("seq_err_load", 32'(error), 32'd0);
    drive(1, 5, 0, 0, 0);
    chk("seq_wr1", 32'(wr), 32'd1);
    chk("seq_data1", cfg_data, 32'd12);
    chk("seq_busy_start", 32'(busy), 32'd1);
    drive(0, 0, 0, 0, 0);
    chk("seq_start", 32'(start_exec), 32'd1);
    chk("seq_max_id_start", 32'(cfg_max), 32'd1);
    drive(0, 0, 0, 0, 0);
    chk("seq_done", 32'(done), 32'd1);
    chk("seq_err_run", 32'(error), 32'd0);

`ifdef ELASTIC_CONFIG_LOADER_CHECKSUM_EN
    // (0x5 ^ 1) ^ (0x3 ^ 2) = 0x5
    row = 2000;
    drive(1, 2, 0, 0, 0);
    drive(0, 0, 1, 5, 1);
    chk("checksum_cleared", cks, 32'h0);
    drive(0, 0, 1, 3, 2);
    chk("checksum_first", cks, 32'h4);
    drive(0, 0, 0, 0, 0);
    chk("checksum_final", cks, 32'h5);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("checksum_done", 32'(done), 32'd1);
    chk("checksum_held", cks, 32'h5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
